// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package im_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    // Same offset as the CPU's PC adder, so loaded words line up with fetch order.
    localparam logic [31:0] ADDR_STEP  = 32'h4;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Collects bytes into a big-endian 32-bit word; the first byte ends up in [31:24].
module byte_packer
    import im_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [1:0]  r_idx;
    logic [31:0] r_word;

    // Shifting left puts each new byte below the earlier ones, which yields big-endian order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
        end else if (i_load) begin
            r_idx  <= r_idx + 2'd1;
            r_word <= {r_word[23:0], i_byte};
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_load && (r_idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/im_loader.sv
// Streams bytes into big-endian words and writes them to sequential IM addresses.
module im_loader
    import im_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             im_we,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [31:0]      r_addr;
    logic             w_start_acc;
    logic             w_load;
    logic             w_word_full;
    logic [31:0]      w_word;

    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_load      = in_valid && (r_state == ST_COLLECT);

    byte_packer u_packer (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (w_start_acc || (r_state == ST_WRITE)),
        .i_load      (w_load),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = (num_words == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_word_full) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_nxt = (r_remaining == CNT_W'(1)) ? ST_DONE : ST_COLLECT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address advances after the WRITE cycle so it is stable while im_we is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= BASE_ADDR;
            r_remaining <= '0;
        end else if (w_start_acc) begin
            r_addr      <= BASE_ADDR;
            r_remaining <= num_words;
        end else if (r_state == ST_WRITE) begin
            r_addr      <= r_addr + ADDR_STEP;
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    assign in_ready = (r_state == ST_COLLECT);
    assign im_we    = (r_state == ST_WRITE);
    assign busy     = (r_state == ST_COLLECT) || (r_state == ST_WRITE);
    assign done     = (r_state == ST_DONE);
    assign im_addr  = r_addr;
    assign im_wdata = w_word;

endmodule
